// File: rtl/mdu_pkg.sv
// Shared MD op encodings, FSM states and helpers
// for the multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_e;

  function automatic logic is_muldiv(
    input logic [3:0] op
  );
    return (op == MD_MULT) || (op == MD_MULTU)
        || (op == MD_DIV)  || (op == MD_DIVU);
  endfunction

  function automatic logic is_div(
    input logic [3:0] op
  );
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// E-stage MD bundle: op/operands/D-stage request in,
// HI/LO/read data/start/busy/stall out.
interface mdu_if;
  logic        md_valid;
  logic [3:0]  md_op;
  logic [31:0] A;
  logic [31:0] B;
  logic        md_req_d;
  logic [31:0] rd_out;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        start;
  logic        busy;
  logic        stall;

  modport master (
    output md_valid, md_op, A, B, md_req_d,
    input  rd_out, hi_out, lo_out,
    input  start, busy, stall
  );

  modport slave (
    input  md_valid, md_op, A, B, md_req_d,
    output rd_out, hi_out, lo_out,
    output start, busy, stall
  );
endinterface

// File: rtl/mdu_calc.sv
// Combinational mult/div datapath.
// Ports: op_i, a_i, b_i -> res_o {hi,lo}, div_zero_o.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o,
  output logic        div_zero_o
);

  logic [63:0] a_sx, b_sx;
  logic [31:0] a_mag, b_mag, b_safe, bm_safe;
  logic [31:0] qm, rm, qs, rs;

  assign a_sx = {{32{a_i[31]}}, a_i};
  assign b_sx = {{32{b_i[31]}}, b_i};

  // Signed divide done on magnitudes; this also
  // makes 0x80000000 / -1 wrap to 0x80000000.
  assign a_mag = a_i[31] ? -a_i : a_i;
  assign b_mag = b_i[31] ? -b_i : b_i;

  // Zero divisor swapped for 1 to keep X out;
  // the result is discarded anyway.
  assign b_safe  = (b_i == '0) ? 32'd1 : b_i;
  assign bm_safe = (b_i == '0) ? 32'd1 : b_mag;

  assign qm = a_mag / bm_safe;
  assign rm = a_mag % bm_safe;
  assign qs = (a_i[31] ^ b_i[31]) ? -qm : qm;
  assign rs = a_i[31] ? -rm : rm;

  always_comb begin
    res_o      = '0;
    div_zero_o = 1'b0;
    unique case (1'b1)
      (op_i == MD_MULT): res_o = a_sx * b_sx;
      (op_i == MD_MULTU):
        res_o = {32'd0, a_i} * {32'd0, b_i};
      (op_i == MD_DIV): begin
        res_o      = {rs, qs};
        div_zero_o = (b_i == '0);
      end
      (op_i == MD_DIVU): begin
        res_o      = {a_i % b_safe, a_i / b_safe};
        div_zero_o = (b_i == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning HI/LO.
// Ports: clk, rst (async high), bus (mdu_if.slave).
module mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES
                               : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  mdu_state_e  state_q;
  logic [CW-1:0] cnt_q;
  logic [3:0]  op_q;
  logic [31:0] a_q, b_q, hi_q, lo_q;
  logic        busy_q;
  logic        start;
  logic        idle_v;
  logic [63:0] res;
  logic        div_zero;

  mdu_calc u_calc (
    .op_i       (op_q),
    .a_i        (a_q),
    .b_i        (b_q),
    .res_o      (res),
    .div_zero_o (div_zero)
  );

  assign idle_v = bus.md_valid
               && (state_q == MDU_IDLE);
  assign start  = idle_v && is_muldiv(bus.md_op);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MDU_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (start) begin
            op_q    <= bus.md_op;
            a_q     <= bus.A;
            b_q     <= bus.B;
            cnt_q   <= is_div(bus.md_op)
                     ? CW'(DIV_CYCLES)
                     : CW'(MULT_CYCLES);
            state_q <= MDU_BUSY;
            busy_q  <= 1'b1;
          end else if (idle_v
                       && bus.md_op == MD_MTHI) begin
            hi_q <= bus.A;
          end else if (idle_v
                       && bus.md_op == MD_MTLO) begin
            lo_q <= bus.A;
          end
        end
        MDU_BUSY: begin
          if (cnt_q == CW'(1)) begin
            if (!div_zero) begin
              hi_q <= res[63:32];
              lo_q <= res[31:0];
            end
            cnt_q   <= '0;
            state_q <= MDU_IDLE;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= MDU_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.rd_out = '0;
    unique case (1'b1)
      (bus.md_op == MD_MFHI): bus.rd_out = hi_q;
      (bus.md_op == MD_MFLO): bus.rd_out = lo_q;
      default: ;
    endcase
  end

  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.start  = start;
  assign bus.busy   = busy_q;
  assign bus.stall  = bus.md_req_d
                   && (start || busy_q);

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu.
// Drives mdu_if, checks HI/LO/busy/stall/start.
module tb_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cnt;

  mdu_if m ();

  mdu #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (m.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h",
             tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic        v,
    input logic [3:0]  op,
    input logic [31:0] a,
    input logic [31:0] b
  );
    m.md_valid = v;
    m.md_op    = op;
    m.A        = a;
    m.B        = b;
  endtask

  task automatic idle();
    drive(1'b0, MD_NONE, '0, '0);
  endtask

  // Count busy-high cycles after the issue edge,
  // bounded so a stuck busy cannot hang the run.
  task automatic run_busy(output int n);
    n = 0;
    while (m.busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    idle();
    m.md_req_d = 1'b0;
    #2;
    chk("rst_hi",   m.hi_out, 32'h0);
    chk("rst_lo",   m.lo_out, 32'h0);
    chk("rst_busy", 32'(m.busy), 32'h0);
    #10 rst = 1'b0;
    step();

    // md_valid=0 ignores op
    drive(1'b0, MD_MULT, 32'd2, 32'd3);
    #1 chk("nv_start", 32'(m.start), 32'h0);
    step();
    chk("nv_busy", 32'(m.busy), 32'h0);

    // MULT signed
    drive(1'b1, MD_MULT, 32'hFFFFFFFE, 32'd3);
    #1 chk("mult_start", 32'(m.start), 32'h1);
    step();
    idle();
    run_busy(cnt);
    chk("mult_bcyc", 32'(cnt), 32'd5);
    chk("mult_hi", m.hi_out, 32'hFFFFFFFF);
    chk("mult_lo", m.lo_out, 32'hFFFFFFFA);

    // MULTU with D-stage MD op: stall count
    m.md_req_d = 1'b1;
    #1 chk("nostall_idle", 32'(m.stall), 32'h0);
    drive(1'b1, MD_MULTU, 32'hFFFFFFFE, 32'd3);
    cnt = 0;
    #1;
    for (int i = 0; i < 9; i++) begin
      if (m.stall === 1'b1) cnt++;
      step();
      idle();
      #1;
    end
    chk("multu_stall", 32'(cnt), 32'd6);
    chk("stall_end", 32'(m.stall), 32'h0);
    m.md_req_d = 1'b0;
    chk("multu_hi", m.hi_out, 32'h00000002);
    chk("multu_lo", m.lo_out, 32'hFFFFFFFA);

    // DIV -7 / 2
    drive(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2);
    step();
    idle();
    run_busy(cnt);
    chk("div_bcyc", 32'(cnt), 32'd10);
    chk("div_lo", m.lo_out, 32'hFFFFFFFD);
    chk("div_hi", m.hi_out, 32'hFFFFFFFF);

    // DIV overflow case
    drive(1'b1, MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    step();
    idle();
    run_busy(cnt);
    chk("ovf_lo", m.lo_out, 32'h80000000);
    chk("ovf_hi", m.hi_out, 32'h0);

    // MTHI / MTLO then DIVU by zero
    drive(1'b1, MD_MTHI, 32'h1234, 32'h0);
    #1 chk("mthi_start", 32'(m.start), 32'h0);
    step();
    chk("mthi_hi", m.hi_out, 32'h1234);
    chk("mthi_busy", 32'(m.busy), 32'h0);
    drive(1'b1, MD_MTLO, 32'h5678, 32'h0);
    step();
    chk("mtlo_lo", m.lo_out, 32'h5678);
    chk("mtlo_hi", m.hi_out, 32'h1234);
    drive(1'b1, MD_DIVU, 32'd77, 32'd0);
    step();
    idle();
    run_busy(cnt);
    chk("dz_bcyc", 32'(cnt), 32'd10);
    chk("dz_hi", m.hi_out, 32'h1234);
    chk("dz_lo", m.lo_out, 32'h5678);
    drive(1'b1, MD_MFHI, '0, '0);
    #1 chk("mfhi", m.rd_out, 32'h1234);
    drive(1'b1, MD_MFLO, '0, '0);
    #1 chk("mflo", m.rd_out, 32'h5678);
    drive(1'b1, MD_NONE, '0, '0);
    #1 chk("rd_none", m.rd_out, 32'h0);
    idle();

    // DIVU 100/7 with MULT presented mid-flight
    drive(1'b1, MD_DIVU, 32'd100, 32'd7);
    step();
    idle();
    step();
    step();
    drive(1'b1, MD_MULT, 32'd9, 32'd9);
    #1 chk("ign_start", 32'(m.start), 32'h0);
    step();
    idle();
    cnt = 3;
    while (m.busy === 1'b1 && cnt < 40) begin
      cnt++;
      step();
    end
    chk("ign_bcyc", 32'(cnt), 32'd10);
    chk("ign_hi", m.hi_out, 32'd2);
    chk("ign_lo", m.lo_out, 32'd14);

    // Async reset mid-flight
    drive(1'b1, MD_DIV, 32'd50, 32'd3);
    step();
    idle();
    step();
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("ar_busy", 32'(m.busy), 32'h0);
    chk("ar_hi", m.hi_out, 32'h0);
    chk("ar_lo", m.lo_out, 32'h0);
    #1 rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (m.busy !== 1'b0 || m.hi_out !== 32'h0
          || m.lo_out !== 32'h0) cnt++;
    end
    chk("ar_nowrite", 32'(cnt), 32'h0);

    $display("%0d/%0d checks passed",
             n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/mdu.md
Name: mdu

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS core.
- Sits beside the ALU in the E stage.
- Sequences mult/div latency with a busy counter and owns architectural HI/LO.
- Provides the stall request that holds the D stage while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- md_valid  in  1  E-stage instruction is valid (not a bubble or flush).
- md_op  in  4  E-stage MD operation, encoded per shared constants.
- A  in  32  rs operand (forwarded).
- B  in  32  rt operand (forwarded).
- md_req_d  in  1  D-stage instruction is any MD op (MULT..MTLO).
- rd_out  out  32  MFHI -> HI, MFLO -> LO, else 0; combinational.
- hi_out  out  32  HI register.
- lo_out  out  32  LO register.
- start  out  1  combinational; high in the issue cycle of MULT/MULTU/DIV/DIVU.
- busy  out  1  registered; high while an operation is in flight.
- stall  out  1  md_req_d & (start | busy).

Behaviour:
- Reset (async, any state): HI=0, LO=0, cnt=0, state=IDLE, busy=0, pending results cleared.
- States: IDLE, BUSY.
- Issue condition: start = md_valid & state==IDLE & md_op in {MULT,MULTU,DIV,DIVU}.
- Issue edge (start=1):
  - Latch op, A and B into the pending registers (compute may occur at issue or at completion; results are identical).
  - cnt <= MULT_CYCLES or DIV_CYCLES; state -> BUSY.
- BUSY: cnt decrements each edge. On the edge where cnt==1:
  - HI/LO are written with the pending result.
  - cnt becomes 0, state -> IDLE, busy falls on that same edge.
  - Net effect: busy is high for exactly N cycles after the issue edge, and the new HI/LO are visible in the first cycle busy=0.
- Arithmetic:
  - MULT: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - MULTU: unsigned 32x32 -> 64; HI=[63:32], LO=[31:0].
  - DIV: LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - DIVU: unsigned; LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF (signed): LO=0x80000000, HI=0.
  - Divide by zero (DIV/DIVU, B==0): full busy period still runs; HI and LO retain their prior values.
- MTHI/MTLO: accepted only in IDLE with md_valid. HI (or LO) <= A at the next edge, no busy cycle.
- MFHI/MFLO: rd_out is a pure combinational read of the current HI/LO; no state change.
- MD op presented while BUSY (stall prevents this in legal flows):
  - Ignored: no start, no HI/LO write, counter undisturbed.
- md_valid=0: md_op ignored entirely.
- stall:
  - Asserted during the issue cycle (via start) and all busy cycles whenever D holds an MD op.
  - Non-MD instructions in D are never stalled.
- Simultaneous events:
  - Completion and a new issue cannot coincide, because issue requires IDLE; back-to-back ops issue in the first IDLE cycle.
  - Reset during BUSY discards the pending op with no HI/LO write.
- Counter width: $clog2(max(MULT_CYCLES,DIV_CYCLES)+1).

Decomposition:
- parameters.v gains MD op encodings:
  - MD_NONE=0, MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4
  - MD_MFHI=5, MD_MFLO=6, MD_MTHI=7, MD_MTLO=8
- parameters.v also gains state encodings MDU_IDLE and MDU_BUSY.
- One sub-module, mdu_calc: purely combinational. Inputs are op, A, B; outputs are the 64-bit {hi,lo} result and a div_zero flag.
- mdu keeps the FSM, counter, pending registers and HI/LO.

Test Plan:
- MULT, A=0xFFFFFFFE, B=3, md_valid=1 -> start=1 in the issue cycle; busy=1 for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- MULTU, same operands -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA; with md_req_d=1 throughout, stall=1 for 6 cycles (issue + 5), then 0.
- DIV, A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV, A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI A=0x1234, then MTLO A=0x5678, then DIVU B=0 -> busy for 10 cycles; HI=0x1234, LO=0x5678 unchanged; MFHI gives rd_out=0x1234.
- DIV in flight; MULT presented at busy cycle 3 -> ignored; only the DIV result is written, at cycle 10.
- DIV issued; rst pulsed asynchronously mid-cycle at busy cycle 4 -> busy=0, HI=LO=0 immediately with no clock edge; no later write occurs.
